// File: rtl/booth_mul_arbiter_pkg.sv
// Shared definitions for the Booth multiplier arbiter slice.
//   WIDTH   : default operand width
//   PW      : product width for the default operand width
//   state_t : arbiter FSM states
package booth_mul_arbiter_pkg;

  localparam int unsigned WIDTH = 5;
  localparam int unsigned PW    = 2 * WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_LOADY,
    ST_LOADX,
    ST_WAIT,
    ST_LOW,
    ST_RESP,
    ST_ABORT
  } state_t;

endpackage

// File: rtl/booth_mul_arbiter_rr_arb2.sv
// Two-way round-robin picker with a last-served register.
//   clk, rst        : clock, synchronous active-high reset (last <= 1)
//   en              : picking enabled (arbiter idle)
//   req0, req1      : requests
//   upd, upd_owner  : record upd_owner as last served
//   gnt0, gnt1      : one-hot grant, only while en
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req0,
  input  logic req1,
  input  logic upd,
  input  logic upd_owner,
  output logic gnt0,
  output logic gnt1
);

  logic last;

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
    end else if (upd) begin
      last <= upd_owner;
    end
  end

  // On a tie, serve whichever requester was not served last.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (en) begin
      if (req0 && req1) begin
        gnt0 = last;
        gnt1 = !last;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

endmodule

// File: rtl/booth_mul_arbiter.sv
// Shares one serial-load Booth multiplier between two requesters.
//   clk, rst                 : clock, synchronous active-high reset
//   req*/a*/b*               : requests and signed operands (X=a, Y=b)
//   gnt*                     : grant pulse, operands captured
//   rsp_valid*, rsp_prod,
//   rsp_err                  : result pulse to owner, product {hi,lo}, abort flag
//   busy                     : arbiter not idle
//   m_start, m_data_in, m_rst: multiplier control / operand bus / reset
//   m_done, m_data_out       : multiplier completion, high then low half
module booth_mul_arbiter #(
  parameter int unsigned WIDTH   = booth_mul_arbiter_pkg::WIDTH,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic               gnt0,
  output logic               gnt1,
  output logic               rsp_valid0,
  output logic               rsp_valid1,
  output logic [2*WIDTH-1:0] rsp_prod,
  output logic               rsp_err,
  output logic               busy,
  output logic               m_start,
  output logic [WIDTH-1:0]   m_data_in,
  output logic               m_rst,
  input  logic               m_done,
  input  logic [WIDTH-1:0]   m_data_out
);

  import booth_mul_arbiter_pkg::*;

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t             state, state_nx;
  logic               owner;
  logic [WIDTH-1:0]   a_q, b_q, hi_q;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] prod_q;
  logic               err_q;
  logic               arb_gnt0, arb_gnt1;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .en        (state == ST_IDLE && !rst),
    .req0      (req0),
    .req1      (req1),
    .upd       (state == ST_RESP),
    .upd_owner (owner),
    .gnt0      (arb_gnt0),
    .gnt1      (arb_gnt1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      owner  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      hi_q   <= '0;
      cnt    <= '0;
      prod_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (arb_gnt0 || arb_gnt1) begin
        owner <= arb_gnt1;
        a_q   <= arb_gnt1 ? a1 : a0;
        b_q   <= arb_gnt1 ? b1 : b0;
      end
      if (state == ST_WAIT) cnt <= cnt + 1'b1;
      else                  cnt <= '0;
      if (state == ST_WAIT && m_done) hi_q <= m_data_out;
      // Output register loads on entry to RESP and holds until the next one.
      if (state == ST_LOW) begin
        prod_q <= {hi_q, m_data_out};
        err_q  <= 1'b0;
      end
      if (state == ST_ABORT) begin
        prod_q <= '0;
        err_q  <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (arb_gnt0 || arb_gnt1) state_nx = ST_START;
      ST_START: state_nx = ST_LOADY;
      ST_LOADY: state_nx = ST_LOADX;
      ST_LOADX: state_nx = ST_WAIT;
      // Completion wins over a timeout landing in the same cycle.
      ST_WAIT: begin
        if (m_done)               state_nx = ST_LOW;
        else if (cnt == CNT_LAST) state_nx = ST_ABORT;
      end
      ST_LOW:   state_nx = ST_RESP;
      ST_ABORT: state_nx = ST_RESP;
      ST_RESP:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt0       = arb_gnt0;
    gnt1       = arb_gnt1;
    rsp_valid0 = !rst && state == ST_RESP && !owner;
    rsp_valid1 = !rst && state == ST_RESP && owner;
    busy       = !rst && state != ST_IDLE;
    m_start    = !rst && state == ST_START;
    m_rst      = rst || state == ST_ABORT;
    m_data_in  = '0;
    if (!rst) begin
      if (state == ST_LOADY) m_data_in = b_q;
      if (state == ST_LOADX) m_data_in = a_q;
    end
    rsp_prod = prod_q;
    rsp_err  = err_q;
  end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
module tb_booth_mul_arbiter;

  localparam int TMO = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [4:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic       gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_err, busy;
  logic       m_start, m_rst;
  logic [9:0] rsp_prod;
  logic [4:0] m_data_in;
  logic       m_done = 1'b0;
  logic [4:0] m_data_out = '0;

  int checks = 0;
  int failures = 0;

  // Reference state kept by the bench
  int         tb_last = 1;
  logic [9:0] last_prod = '0;
  logic       last_err = 1'b0;

  booth_mul_arbiter #(.WIDTH(5), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
    .rsp_prod(rsp_prod), .rsp_err(rsp_err), .busy(busy),
    .m_start(m_start), .m_data_in(m_data_in), .m_rst(m_rst),
    .m_done(m_done), .m_data_out(m_data_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] ref_mul(input logic [4:0] x, input logic [4:0] y);
    int sx, sy;
    sx = $signed(x);
    sy = $signed(y);
    return 10'(sx * sy);
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  // Drives a request from IDLE through the operand load; returns owner and product.
  task automatic start_txn(input logic r0, input logic r1,
                           input logic [4:0] x0, input logic [4:0] y0,
                           input logic [4:0] x1, input logic [4:0] y1,
                           input bit keep, output int owner, output logic [9:0] prod);
    logic [4:0] ea, eb;
    if (r0 && r1) owner = (tb_last == 1) ? 0 : 1;
    else          owner = r0 ? 0 : 1;
    ea = (owner == 0) ? x0 : x1;
    eb = (owner == 0) ? y0 : y1;
    prod = ref_mul(ea, eb);
    step();
    req0 = r0; req1 = r1; a0 = x0; b0 = y0; a1 = x1; b1 = y1;
    #1;
    chk("gnt0", gnt0, owner == 0);
    chk("gnt1", gnt1, owner == 1);
    chk("idle_busy", busy, 0);
    chk("hold_prod", rsp_prod, last_prod);
    chk("hold_err", rsp_err, last_err);
    step();
    if (!keep) begin
      if (owner == 0) begin req0 = 1'b0; a0 = 5'($urandom); b0 = 5'($urandom); end
      else            begin req1 = 1'b0; a1 = 5'($urandom); b1 = 5'($urandom); end
    end
    #1;
    chk("start", m_start, 1);
    chk("start_bus", m_data_in, 0);
    chk("start_busy", busy, 1);
    chk("start_nogrant", {gnt0, gnt1}, 0);
    step(); #1;
    chk("bus_y", m_data_in, eb);
    chk("start_off", m_start, 0);
    step(); #1;
    chk("bus_x", m_data_in, ea);
  endtask

  // Multiplier answers after lat WAIT cycles.
  task automatic finish_done(input int lat, input int owner, input logic [9:0] prod);
    for (int i = 0; i < lat; i++) begin
      step();
      m_done = 1'b0; m_data_out = 5'($urandom);
      #1;
      chk("wait_novalid", {rsp_valid0, rsp_valid1}, 0);
      chk("wait_bus", m_data_in, 0);
    end
    step();
    m_done = 1'b1; m_data_out = prod[9:5];
    step();
    m_done = 1'b0; m_data_out = prod[4:0];
    #1;
    chk("low_novalid", {rsp_valid0, rsp_valid1}, 0);
    step();
    m_data_out = 5'($urandom);
    #1;
    chk("rsp_valid0", rsp_valid0, owner == 0);
    chk("rsp_valid1", rsp_valid1, owner == 1);
    chk("rsp_prod", rsp_prod, prod);
    chk("rsp_err", rsp_err, 0);
    tb_last = owner; last_prod = prod; last_err = 1'b0;
  endtask

  // Multiplier never answers.
  task automatic finish_timeout(input int owner);
    for (int i = 0; i < TMO; i++) begin
      step();
      m_done = 1'b0; m_data_out = 5'($urandom);
      #1;
      chk("tmo_nomrst", m_rst, 0);
      chk("tmo_novalid", {rsp_valid0, rsp_valid1}, 0);
    end
    step(); #1;
    chk("abort_mrst", m_rst, 1);
    chk("abort_busy", busy, 1);
    step(); #1;
    chk("tmo_valid0", rsp_valid0, owner == 0);
    chk("tmo_valid1", rsp_valid1, owner == 1);
    chk("tmo_err", rsp_err, 1);
    chk("tmo_prod", rsp_prod, 0);
    chk("tmo_mrst_off", m_rst, 0);
    tb_last = owner; last_prod = '0; last_err = 1'b1;
  endtask

  initial begin
    int         own;
    logic [9:0] p;
    int         pat;
    logic [4:0] ra0, rb0, ra1, rb1;

    // Reset
    step(); step(); #1;
    chk("rst_busy", busy, 0);
    chk("rst_mrst", m_rst, 1);
    chk("rst_gnt", {gnt0, gnt1}, 0);
    chk("rst_valid", {rsp_valid0, rsp_valid1}, 0);
    chk("rst_prod", rsp_prod, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_start", m_start, 0);
    chk("rst_bus", m_data_in, 0);
    rst = 1'b0;

    // Both requesters held: alternating service 0,1,0,1
    for (int k = 0; k < 4; k++) begin
      start_txn(1, 1, 5'd3, 5'd5, 5'h1D, 5'd7, 1'b1, own, p);
      finish_done(k + 1, own, p);
    end
    step(); req0 = 1'b0; req1 = 1'b0;
    #1;
    chk("drop_idle", busy, 0);

    // Single requesters
    start_txn(1, 0, 5'd3, 5'd5, 5'd0, 5'd0, 1'b0, own, p);
    finish_done(3, own, p);
    start_txn(0, 1, 5'd0, 5'd0, 5'h1D, 5'd7, 1'b0, own, p);
    finish_done(0, own, p);

    // Timeout
    start_txn(1, 0, 5'd9, 5'h12, 5'd0, 5'd0, 1'b0, own, p);
    finish_timeout(own);
    step(); #1;
    chk("post_tmo_idle", busy, 0);

    // Completion on the final allowed WAIT cycle
    start_txn(0, 1, 5'd0, 5'd0, 5'h10, 5'h10, 1'b0, own, p);
    finish_done(TMO - 1, own, p);

    // Spurious m_done while idle
    step();
    m_done = 1'b1; m_data_out = 5'h1F;
    #1;
    chk("spur_busy", busy, 0);
    step();
    m_done = 1'b0;
    #1;
    chk("spur_novalid", {rsp_valid0, rsp_valid1}, 0);
    chk("spur_idle", busy, 0);
    start_txn(1, 0, 5'h1C, 5'h1B, 5'd0, 5'd0, 1'b0, own, p);
    finish_done(2, own, p);

    // Reset mid-WAIT
    start_txn(0, 1, 5'd0, 5'd0, 5'd6, 5'd6, 1'b0, own, p);
    step(); step(); #1;
    chk("midwait_busy", busy, 1);
    step();
    rst = 1'b1;
    #1;
    chk("midrst_mrst", m_rst, 1);
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_valid", {rsp_valid0, rsp_valid1}, 0);
    chk("post_rst_prod", rsp_prod, 0);
    chk("post_rst_err", rsp_err, 0);
    chk("post_rst_bus", m_data_in, 0);
    chk("post_rst_mrst", m_rst, 0);
    tb_last = 1; last_prod = '0; last_err = 1'b0;
    step(); #1;
    chk("post_rst_quiet", {rsp_valid0, rsp_valid1}, 0);
    start_txn(1, 1, 5'd4, 5'h1E, 5'd1, 5'd1, 1'b0, own, p);
    finish_done(1, own, p);

    // Randomized traffic
    for (int k = 0; k < 16; k++) begin
      pat = $urandom_range(1, 3);
      ra0 = 5'($urandom); rb0 = 5'($urandom);
      ra1 = 5'($urandom); rb1 = 5'($urandom);
      start_txn(pat[0], pat[1], ra0, rb0, ra1, rb1, 1'b0, own, p);
      if ($urandom_range(0, 7) == 0) finish_timeout(own);
      else                           finish_done($urandom_range(0, TMO - 1), own, p);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/booth_mul_arbiter.md
# booth_mul_arbiter

Shares one serial-load Booth multiplier (5-bit signed operands, 10-bit product returned in two 5-bit halves) between two independent requesters. Grants round-robin, marshals the granted operands onto the multiplier's single data_in bus, collects the two product halves and returns a full product to the owning requester. A watchdog aborts a stalled multiplication and reports an error. Sits between client logic and the multiplier instance in the top level.

## Interface
- WIDTH, 5: operand width; product is 2*WIDTH.
- TIMEOUT, 32: maximum WAIT cycles before abort (≥ 2).
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- req0, req1  in  1  level request, held until the matching gnt.
- a0, b0, a1, b1  in  WIDTH  signed operands (X=a, Y=b), sampled in the gnt cycle.
- gnt0, gnt1  out  1  one-cycle pulse; operands captured this cycle.
- rsp_valid0, rsp_valid1  out  1  one-cycle result pulse to the owner.
- rsp_prod  out  2*WIDTH  product {high, low}, valid with rsp_valid*.
- rsp_err  out  1  watchdog abort flag, valid with rsp_valid*.
- busy  out  1  high in every state except IDLE.
- m_start  out  1  multiplier start pulse.
- m_data_in  out  WIDTH  multiplier operand bus.
- m_rst  out  1  multiplier reset = rst OR abort pulse.
- m_done  in  1  multiplier completion pulse.
- m_data_out  in  WIDTH  high half in the m_done cycle, low half the next cycle.

## Operation
- FSM: IDLE → START → LOADY → LOADX → WAIT → LOW → RESP → IDLE; ABORT → RESP on timeout.
- IDLE: if any req, grant per priority; latch owner, a, b; go START. No req: stay.
- Priority: grant the requester not served last; single requester always wins. After reset last=1, so req0 wins a tie.
- START: m_start=1, m_data_in=0. LOADY: m_data_in=b. LOADX: m_data_in=a. In all other states m_data_in=0 and m_start=0.
- WAIT: the watchdog counts cycles from 0. On m_done, capture m_data_out as the high half and go LOW. If the count reaches TIMEOUT-1 without m_done, go ABORT.
- LOW: capture m_data_out as the low half; go RESP.
- ABORT: m_rst=1 for one cycle; product register cleared to 0; err set.
- RESP: rsp_valid of owner =1, rsp_prod and rsp_err driven; update last=owner; go IDLE.
- A req dropped before its gnt is ignored. A req still high in RESP is not granted until IDLE.
- The product is passed through as is; no sign correction is done here.
- rsp_prod and rsp_err hold their last value between responses.

## Timing
- Reset (rst high at edge): state IDLE; gnt*, rsp_valid*, m_start, busy, rsp_err =0; rsp_prod=0; m_data_in=0; m_rst=1 while rst high; counter=0; last=1.
- rst asserted in any state, including WAIT: next cycle IDLE, no rsp_valid. The in-flight request is discarded and the multiplier is reset through m_rst.
- Grant at cycle T (IDLE). m_start at T+1, b on bus at T+2, a on bus at T+3, WAIT from T+4.
- m_done at cycle D ≥ T+4: low half captured at D+1, rsp_valid at D+2. A new grant is possible at D+3 at the earliest.
- Timeout: ABORT at T+4+TIMEOUT, rsp_valid with err=1 one cycle later.
- m_done outside WAIT is ignored.

## Structure
- A shared package holds the state enum, the WIDTH default, and the product width constant PW=2*WIDTH.
- One natural sub-module: rr_arb2 (2-way round-robin picker with a last-served register, enabled only in IDLE).
- FSM, operand/product registers and watchdog live in booth_mul_arbiter.

## Test plan
- req0 with a0=3, b0=5; the bus model returns 15 → gnt0 at T; m_data_in 5 then 3; rsp_valid0 with rsp_prod=10'd15, err=0.
- req1 with a1=-3, b1=7 → rsp_valid1 with rsp_prod=10'h3EB (-21).
- req0 and req1 high from reset, held → grants in order 0, 1, 0, 1. Each rsp_valid goes to the matching owner. No overlap: busy is high between gnt and rsp.
- The model never asserts m_done with TIMEOUT=32 → m_rst pulse at T+36, rsp_valid0 with err=1 and prod=0 at T+37, then idle.
- rst asserted for one cycle mid-WAIT → all outputs at reset values, no rsp_valid. A following req0 with a simultaneous req1 is granted to req0.
- m_done pulsed while IDLE, then a normal request → the spurious pulse is ignored and the product is correct.
